// File: rtl/uvme_cvmcu_probe_evt_tx.sv
// ---------------------------------------------------------------------------
// uvme_cvmcu_probe_evt_tx
//
// DUT-side producer for the CORE-V MCU probe channel. Each cycle the event
// vector is sampled. A non-zero vector, seen while enabled, is stamped with a
// free-running timestamp. The resulting record is buffered in a small FIFO and
// offered to the env probe monitor over a valid/ready stream.
//
// Records that arrive while the FIFO is full are dropped and counted. The next
// record that is written successfully carries a "lost" flag. A flush that
// throws away buffered records also raises that flag.
//
// Ports
//   clk        sole clock, all logic on posedge
//   reset      synchronous, active-high reset
//   enable     1 = timestamp counts and events are captured
//   flush      one-cycle pulse that discards the FIFO contents
//   evt_i      event pulse vector, sampled every cycle
//   rec_valid  record available on rec_data
//   rec_ready  consumer accepts the presented record
//   rec_data   {lost, ts, events}
//   level      FIFO occupancy in records
//   ovf_cnt    dropped-record count, saturating at 16'hFFFF
// ---------------------------------------------------------------------------
module uvme_cvmcu_probe_evt_tx #(
  parameter int EVENT_W = 8,
  parameter int TS_W    = 16,
  parameter int DEPTH   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      flush,
  input  logic [EVENT_W-1:0]        evt_i,
  output logic                      rec_valid,
  input  logic                      rec_ready,
  output logic [TS_W+EVENT_W:0]     rec_data,
  output logic [$clog2(DEPTH):0]    level,
  output logic [15:0]               ovf_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 1 + TS_W + EVENT_W;

  logic [TS_W-1:0]  ts_q;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             lost_pend_q, lost_pend_d;
  logic [15:0]      ovf_cnt_q, ovf_cnt_d;
  logic [REC_W-1:0] mem_q [DEPTH];

  logic [AW:0]      level_w;
  logic             full_w;
  logic             push_req;
  logic             pop;
  logic             do_write;
  logic             do_drop;

  // The pointers carry one extra MSB, so their difference gives occupancy
  // from 0 up to DEPTH with no separate full flag.
  assign level_w  = wr_ptr_q - rd_ptr_q;
  assign full_w   = (level_w == (AW+1)'(DEPTH));

  // A capture that coincides with a flush is thrown away along with the FIFO.
  assign push_req = enable && (|evt_i) && !flush;
  assign pop      = rec_valid && rec_ready;

  // When the FIFO is full, a pop in the same cycle frees a slot, so the push
  // can still be accepted.
  assign do_write = push_req && (!full_w || pop);
  assign do_drop  = push_req && full_w && !pop;

  // The timestamp counts only while enabled and wraps without notice.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts_q <= '0;
    end else if (enable) begin
      ts_q <= ts_q + TS_W'(1);
    end
  end

  // Next-state logic for the FIFO control, the lost flag and the overflow
  // counter. Flush takes priority over everything else. A flush that discards
  // records raises the lost flag but leaves the drop counter alone.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    lost_pend_d = lost_pend_q;
    ovf_cnt_d   = ovf_cnt_q;
    if (flush) begin
      rd_ptr_d    = wr_ptr_q;
      lost_pend_d = lost_pend_q | (level_w != '0);
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + (AW+1)'(1);
      end
      if (do_write) begin
        wr_ptr_d    = wr_ptr_q + (AW+1)'(1);
        lost_pend_d = 1'b0;
      end
      if (do_drop) begin
        lost_pend_d = 1'b1;
        if (ovf_cnt_q != 16'hFFFF) begin
          ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      lost_pend_q <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      lost_pend_q <= lost_pend_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  // The storage array is not reset. Stale entries can never be seen, because
  // the output is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (!reset && do_write) begin
      mem_q[wr_ptr_q[AW-1:0]] <= {lost_pend_q, ts_q, evt_i};
    end
  end

  // First-word fall-through: the head entry is driven straight from storage.
  assign rec_valid = (level_w != '0);
  assign rec_data  = rec_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign level     = level_w;
  assign ovf_cnt   = ovf_cnt_q;

endmodule
